lane_pipe_reg: RTL
==================

Name: lane_pipe_reg

Overview:
- Parametrised N-lane inter-stage pipeline register for the dual/multi-issue MIPS core; replaces the hand-written per-stage registers (id/ex, ex/mem, mem/wb).
- Per-lane valid, payload, exception type and delay-slot flag are carried independently; every lane keeps its own exception word.
- Adds partial (younger-lane) kill on branch flush and saturating hold/bubble performance counters, neither of which the current per-stage registers have.

Parameters:
- LANES, 2, issue width (1..4).
- DATA_W, 128, per-lane payload bits; all-zero payload encodes a NOP (we=0, aluop=NOP).
- EXC_W, 32, per-lane exception-type bits.
- UP_IDX, 1, index of this stage's upstream bit in stall.
- DN_IDX, 2, index of this stage's downstream bit in stall.
- STALL_W, 4, stall vector width.
- CNT_W, 16, performance counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  flush request.
- flush_cause  in  1  1 = exception (kill all), 0 = branch (kill lanes >= kill_lane).
- kill_lane  in  $clog2(LANES+1)  first killed lane on a branch flush; value LANES kills none.
- stall  in  STALL_W  global stall vector; 1 = Stop.
- in_valid  in  LANES  per-lane valid.
- in_data  in  LANES*DATA_W  payload; lane i occupies [i*DATA_W +: DATA_W].
- in_exc  in  LANES*EXC_W  exception types, same packing as in_data.
- in_dslot  in  LANES  in-delay-slot flags.
- out_valid  out  LANES  registered valid.
- out_data  out  LANES*DATA_W  registered payload.
- out_exc  out  LANES*EXC_W  registered exception types.
- out_dslot  out  LANES  registered delay-slot flags.
- perf_clr  in  1  synchronous clear of both counters.
- hold_cnt  out  CNT_W  hold cycles, saturating.
- bubble_cnt  out  CNT_W  bubble cycles, saturating.

Behaviour:
- All state updates on posedge clk. Latency is 1 cycle in to out.
- A lane is zeroed when valid=0, data=0, exc=0 and dslot=0. A lane written with valid=0 is always zeroed; the register never holds stale payload behind valid=0.
- Reset: all lanes zeroed and both counters 0.
- Per-cycle priority, highest first:
  - 1. rst: all outputs reset as above.
  - 2. flush & flush_cause=1: all lanes zeroed; counters unchanged.
  - 3. Bubble, when stall[UP_IDX]=1 & stall[DN_IDX]=0: all lanes zeroed; bubble_cnt++.
  - 4. Capture, when stall[UP_IDX]=0: lane i <= input lane i, with valid = in_valid[i]; input lanes with in_valid=0 are loaded zeroed.
  - 5. Hold, when stall[UP_IDX]=1 & stall[DN_IDX]=1: outputs retained; hold_cnt++.
- Branch kill: when flush=1 & flush_cause=0, every lane i >= kill_lane is zeroed in the next state. This applies in both the capture and hold cases; lanes < kill_lane load or keep their data as normal. Branch kill together with a bubble gives all lanes zeroed.
- kill_lane > LANES is treated as LANES (no kill).
- Counters:
  - Saturate at all-ones with no wrap.
  - perf_clr sets a counter to 0 and outranks an increment in the same cycle; rst outranks perf_clr.
  - Neither counter changes on flush or capture cycles.
- No combinational path from any input to any output; the counters are registered.

Decomposition:
- Shared package (the defines file): stall-bit polarity constants (Stop/NoStop), flush-cause encodings (Exception/Branch) and the NOP-payload-is-zero rule.
- Per-stage payload field offsets live in that package so the id/ex, ex/mem and mem/wb instances pack and unpack consistently.
- One natural sub-module: sat_counter (CNT_W, inc, clr), instantiated twice.
- Lane logic is a generate loop; no further sub-modules.

Test Plan (LANES=2, DATA_W=8, EXC_W=8, CNT_W=4):
- Reset, capture and per-lane exception:
  - Assert rst for 2 cycles, then stall=0, in_valid=2'b11, data {8'hB2, 8'hA1}, exc {8'h0C, 8'h00} -> next cycle out_valid=2'b11, out_data={B2,A1}, out_exc={0C,00}.
  - Lane 1 keeps its own exception word, not lane 0's.
- Bubble versus hold:
  - stall=4'b0010 -> all lanes zeroed, bubble_cnt=1.
  - Then stall=4'b0110 for 3 cycles -> outputs stay zeroed, hold_cnt=3.
- Hold keeps data: capture {B2,A1}, then stall=4'b0110 for 2 cycles -> out_data stays {B2,A1}, hold_cnt=2.
- Branch kill:
  - flush=1, flush_cause=0, kill_lane=1 during capture of {D4,C3} -> out_valid=2'b01, out_data={00,C3}.
  - Repeat with kill_lane=2 -> out_valid=2'b11.
- Exception flush priority: flush=1, flush_cause=1 with stall=4'b0110 and valid held data -> all lanes zeroed, hold_cnt unchanged.
- Counter saturation and clear:
  - 20 hold cycles -> hold_cnt=4'hF.
  - perf_clr together with a hold -> hold_cnt=0 next cycle.
  - rst together with perf_clr -> 0.

Source files
------------

// File: rtl/lane_pipe_reg_pkg.sv
// Shared definitions for the inter-stage pipeline registers: stall/flush encodings,
// stage action decode and the payload field map used by id/ex, ex/mem and mem/wb.
package lane_pipe_reg_pkg;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   typedef enum logic {
      CAUSE_BRANCH    = 1'b0,
      CAUSE_EXCEPTION = 1'b1
   } flush_cause_e;

   typedef enum logic [1:0] {
      ACT_CAPTURE = 2'd0,
      ACT_HOLD    = 2'd1,
      ACT_BUBBLE  = 2'd2,
      ACT_FLUSH   = 2'd3
   } stage_act_e;

   // An all-zero payload is a NOP: we=0 and aluop=NOP both decode from zero bits.
   localparam int unsigned PL_PC_LSB     = 0;
   localparam int unsigned PL_PC_W       = 32;
   localparam int unsigned PL_INSTR_LSB  = 32;
   localparam int unsigned PL_INSTR_W    = 32;
   localparam int unsigned PL_RESULT_LSB = 64;
   localparam int unsigned PL_RESULT_W   = 32;
   localparam int unsigned PL_DEST_LSB   = 96;
   localparam int unsigned PL_DEST_W     = 5;
   localparam int unsigned PL_WE_BIT     = 101;
   localparam int unsigned PL_ALUOP_LSB  = 102;
   localparam int unsigned PL_ALUOP_W    = 6;
   localparam logic [5:0]  ALUOP_NOP     = 6'd0;

   // Exception flush outranks everything; otherwise the upstream/downstream stall
   // pair selects capture, hold or bubble.
   function automatic stage_act_e decode_act(
      input logic flush,
      input logic flush_cause,
      input logic up_stall,
      input logic dn_stall
   );
      if (flush && (flush_cause == CAUSE_EXCEPTION)) return ACT_FLUSH;
      if (up_stall == NO_STOP)                       return ACT_CAPTURE;
      if (dn_stall == STOP)                          return ACT_HOLD;
      return ACT_BUBBLE;
   endfunction

endpackage

// File: rtl/lane_pipe_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear outranks increment.
module lane_pipe_reg_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/lane_pipe_reg.sv
// N-lane inter-stage pipeline register with per-lane exception words, younger-lane
// branch kill and saturating hold/bubble counters.
module lane_pipe_reg
   import lane_pipe_reg_pkg::*;
#(
   parameter int LANES   = 2,
   parameter int DATA_W  = 128,
   parameter int EXC_W   = 32,
   parameter int UP_IDX  = 1,
   parameter int DN_IDX  = 2,
   parameter int STALL_W = 4,
   parameter int CNT_W   = 16,
   localparam int KL_W   = $clog2(LANES + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    flush_cause,
   input  logic [KL_W-1:0]         kill_lane,
   input  logic [STALL_W-1:0]      stall,
   input  logic [LANES-1:0]        in_valid,
   input  logic [LANES*DATA_W-1:0] in_data,
   input  logic [LANES*EXC_W-1:0]  in_exc,
   input  logic [LANES-1:0]        in_dslot,
   output logic [LANES-1:0]        out_valid,
   output logic [LANES*DATA_W-1:0] out_data,
   output logic [LANES*EXC_W-1:0]  out_exc,
   output logic [LANES-1:0]        out_dslot,
   input  logic                    perf_clr,
   output logic [CNT_W-1:0]        hold_cnt,
   output logic [CNT_W-1:0]        bubble_cnt
);

   stage_act_e act;
   logic       branch_kill;
   logic       hold_inc;
   logic       bubble_inc;
   logic       unused_stall;

   assign act          = decode_act(flush, flush_cause, stall[UP_IDX], stall[DN_IDX]);
   assign branch_kill  = flush && (flush_cause == CAUSE_BRANCH);
   assign unused_stall = ^stall;

   // Any flush cycle, even a branch kill that coincides with a hold, is not counted.
   assign hold_inc   = (act == ACT_HOLD) && !flush;
   assign bubble_inc = (act == ACT_BUBBLE) && !flush;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      localparam logic [KL_W-1:0] LANE_IDX = KL_W'(i);

      logic              valid_q, valid_d;
      logic [DATA_W-1:0] data_q, data_d;
      logic [EXC_W-1:0]  exc_q, exc_d;
      logic              dslot_q, dslot_d;
      logic              kill;

      // kill_lane beyond LANES never satisfies this, so it naturally means "no kill".
      assign kill = branch_kill && (LANE_IDX >= kill_lane);

      always_comb begin
         valid_d = valid_q;
         data_d  = data_q;
         exc_d   = exc_q;
         dslot_d = dslot_q;
         case (act)
            ACT_CAPTURE: begin
               valid_d = in_valid[i];
               data_d  = in_valid[i] ? in_data[i*DATA_W +: DATA_W] : '0;
               exc_d   = in_valid[i] ? in_exc[i*EXC_W +: EXC_W]    : '0;
               dslot_d = in_valid[i] ? in_dslot[i]                 : 1'b0;
            end
            ACT_HOLD: begin
            end
            default: begin
               valid_d = 1'b0;
               data_d  = '0;
               exc_d   = '0;
               dslot_d = 1'b0;
            end
         endcase
         if (kill) begin
            valid_d = 1'b0;
            data_d  = '0;
            exc_d   = '0;
            dslot_d = 1'b0;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            exc_q   <= '0;
            dslot_q <= 1'b0;
         end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            exc_q   <= exc_d;
            dslot_q <= dslot_d;
         end
      end

      assign out_valid[i]                 = valid_q;
      assign out_data[i*DATA_W +: DATA_W] = data_q;
      assign out_exc[i*EXC_W +: EXC_W]    = exc_q;
      assign out_dslot[i]                 = dslot_q;
   end

   lane_pipe_reg_sat_counter #(
      .CNT_W (CNT_W)
   ) u_hold_cnt (
      .clk (clk),
      .rst (rst),
      .inc (hold_inc),
      .clr (perf_clr),
      .cnt (hold_cnt)
   );

   lane_pipe_reg_sat_counter #(
      .CNT_W (CNT_W)
   ) u_bubble_cnt (
      .clk (clk),
      .rst (rst),
      .inc (bubble_inc),
      .clr (perf_clr),
      .cnt (bubble_cnt)
   );

endmodule
